// File: rtl/hl_board_pkg.sv
// Shared types and helpers for the Hermes Lite board-glue controller.
package hl_board_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TX      = 2'd1,
        LOCKOUT = 2'd2
    } ptt_state_t;

    localparam int HEARTBEAT_HALF_MS = 500;

    // Width of a counter that must hold 0..ms without wrapping.
    function automatic int ms_cnt_width(input int ms);
        return (ms < 1) ? 1 : $clog2(ms + 1);
    endfunction

endpackage

// File: rtl/hl_debounce.sv
// One DIP-switch bit: 2-flop synchroniser, millisecond hold counter and change pulse.
module hl_debounce
    import hl_board_pkg::*;
#(
    parameter int DEBOUNCE_MS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_ms,
    input  logic raw,
    output logic level,
    output logic changed
);

    localparam int CW = ms_cnt_width(DEBOUNCE_MS);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_MS);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            changed <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            changed <= 1'b0;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level   <= sync_q2;
                cnt     <= '0;
                changed <= 1'b1;
            end else if (tick_ms) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hl_board_ctrl.sv
// Board glue: ms prescaler, DIP debounce, LED stretchers and PTT watchdog FSM.
// Build option: define HL_BOARD_HEARTBEAT_EN to turn leds[NLED-1] into a 1 Hz heartbeat.
module hl_board_ctrl
    import hl_board_pkg::*;
#(
    parameter int CLK_FREQ       = 73728000,
    parameter int NSW            = 3,
    parameter int NLED           = 8,
    parameter int DEBOUNCE_MS    = 10,
    parameter int STRETCH_MS     = 50,
    parameter int PTT_TIMEOUT_MS = 120000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSW-1:0]  dipsw_raw,
    output logic [NSW-1:0]  dipsw_db,
    output logic            sw_changed,
    input  logic [NLED-1:0] led_act,
    output logic [NLED-1:0] leds,
    input  logic            ptt_req,
    input  logic            tx_inhibit,
    output logic            exp_ptt_n,
    output logic            ptt_timeout,
    output logic            tick_ms
);

    localparam int PRESCALE = CLK_FREQ / 1000;
    localparam int PW = ms_cnt_width(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick_ms <= 1'b0;
        end else begin
            tick_ms <= (pre_cnt == PRE_MAX);
            pre_cnt <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + 1'b1;
        end
    end

    logic [NSW-1:0] sw_change;

    for (genvar i = 0; i < NSW; i++) begin : g_sw
        hl_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick_ms (tick_ms),
            .raw     (dipsw_raw[i]),
            .level   (dipsw_db[i]),
            .changed (sw_change[i])
        );
    end

    assign sw_changed = |sw_change;

    localparam int SW = ms_cnt_width(STRETCH_MS);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_MS);

`ifdef HL_BOARD_HEARTBEAT_EN
    localparam int NSTR = NLED - 1;
    localparam int HW = ms_cnt_width(HEARTBEAT_HALF_MS - 1);
    localparam logic [HW-1:0] HB_MAX = HW'(HEARTBEAT_HALF_MS - 1);

    logic [HW-1:0] hb_cnt;
    logic          hb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt <= '0;
            hb     <= 1'b0;
        end else if (tick_ms) begin
            if (hb_cnt == HB_MAX) begin
                hb_cnt <= '0;
                hb     <= ~hb;
            end else begin
                hb_cnt <= hb_cnt + 1'b1;
            end
        end
    end

    assign leds[NLED-1] = hb;
`else
    localparam int NSTR = NLED;
`endif

    for (genvar i = 0; i < NSTR; i++) begin : g_led
        logic [SW-1:0] cnt;

        // NOTE: each stretcher counter is reset individually so leds drop the instant rst_n falls.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (led_act[i]) begin
                cnt <= STRETCH_LOAD;
            end else if (tick_ms && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end

        assign leds[i] = (cnt != '0);
    end

    localparam int TW = ms_cnt_width(PTT_TIMEOUT_MS);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(PTT_TIMEOUT_MS);
    localparam bit WDOG_EN = (PTT_TIMEOUT_MS != 0);

    ptt_state_t    state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic          timeout_d;
    logic          ptt_n_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            ptt_timeout <= 1'b0;
            exp_ptt_n   <= 1'b1;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            ptt_timeout <= timeout_d;
            exp_ptt_n   <= ptt_n_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state;
        timer_d   = timer;
        timeout_d = ptt_timeout;
        unique case (state)
            IDLE: begin
                if (ptt_req && !tx_inhibit) begin
                    state_d   = TX;
                    timer_d   = TIMER_LOAD;
                    timeout_d = 1'b0;
                end
            end
            TX: begin
                if (tick_ms && timer != '0) timer_d = timer - 1'b1;
                if (!ptt_req) begin
                    state_d = IDLE;
                end else if (tx_inhibit) begin
                    state_d = LOCKOUT;
                end else if (WDOG_EN && timer == '0) begin
                    state_d   = LOCKOUT;
                    timeout_d = 1'b1;
                end
            end
            LOCKOUT: begin
                if (!ptt_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Key only once TX has been held a full cycle; drop on the same edge TX is left.
        ptt_n_d = !(state == TX && state_d == TX);
    end

endmodule

// File: tb/tb_hl_board_ctrl.sv
// Directed self-checking bench for hl_board_ctrl (tick every 10 clk, debounce 3, stretch 4, timeout 20).
module tb_hl_board_ctrl;

    localparam int NSW  = 3;
    localparam int NLED = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NSW-1:0]  dipsw_raw;
    logic [NSW-1:0]  dipsw_db;
    logic            sw_changed;
    logic [NLED-1:0] led_act;
    logic [NLED-1:0] leds;
    logic            ptt_req;
    logic            tx_inhibit;
    logic            exp_ptt_n;
    logic            ptt_timeout;
    logic            tick_ms;

    int n_total   = 0;
    int n_pass    = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int sw_pulses = 0;

    always #5 clk = ~clk;

    hl_board_ctrl #(
        .CLK_FREQ       (10000),
        .NSW            (NSW),
        .NLED           (NLED),
        .DEBOUNCE_MS    (3),
        .STRETCH_MS     (4),
        .PTT_TIMEOUT_MS (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dipsw_raw   (dipsw_raw),
        .dipsw_db    (dipsw_db),
        .sw_changed  (sw_changed),
        .led_act     (led_act),
        .leds        (leds),
        .ptt_req     (ptt_req),
        .tx_inhibit  (tx_inhibit),
        .exp_ptt_n   (exp_ptt_n),
        .ptt_timeout (ptt_timeout),
        .tick_ms     (tick_ms)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to the falling edge after rising edge number 'target' since reset release.
    task automatic run_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
            if (sw_changed === 1'b1) sw_pulses++;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        dipsw_raw  = '0;
        led_act    = '0;
        ptt_req    = 1'b0;
        tx_inhibit = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_dipsw_db", dipsw_db, 0);
        check("rst_sw_changed", sw_changed, 0);
        check("rst_leds", leds, 0);
        check("rst_exp_ptt_n", exp_ptt_n, 1);
        check("rst_ptt_timeout", ptt_timeout, 0);
        check("rst_tick_ms", tick_ms, 0);

        rst_n = 1'b1;
        cyc   = 0;

        // Switch 1 held high: sync by edge 2, ticks at 11/21/31, commit at edge 32.
        dipsw_raw = 3'b010;
        sw_pulses = 0;
        run_to(9);  check("tick_pre", tick_ms, 0);
        run_to(10); check("tick_first", tick_ms, 1);
        run_to(11); check("tick_after", tick_ms, 0);
        run_to(20); check("tick_second", tick_ms, 1);
        run_to(31); check("sw1_before", dipsw_db, 3'b000);
        run_to(32); check("sw1_after", dipsw_db, 3'b010);
                    check("sw1_pulse", sw_changed, 1);
        run_to(33); check("sw1_pulse_end", sw_changed, 0);
        run_to(40); check("sw1_pulse_count", sw_pulses, 1);

        // Switch 0 glitch for 25 clk only reaches two ticks before clearing.
        dipsw_raw = 3'b011;
        sw_pulses = 0;
        run_to(65);
        dipsw_raw = 3'b010;
        run_to(100);
        check("glitch_db", dipsw_db, 3'b010);
        check("glitch_pulses", sw_pulses, 0);

        // LED 2 pulse loads at edge 111 (same edge as a tick), dies at tick 151.
        run_to(110); check("led_idle", leds, 8'h00);
        led_act = 8'h04;
        run_to(111); check("led_on", leds, 8'h04);
        led_act = 8'h00;
        run_to(150); check("led_hold", leds, 8'h04);
        run_to(151); check("led_off", leds, 8'h00);

        // Retrigger 20 clk later extends to tick 221.
        run_to(160); led_act = 8'h04;
        run_to(161); led_act = 8'h00;
        run_to(180); led_act = 8'h04;
        run_to(181); led_act = 8'h00;
        run_to(201); check("led_retrig_hold", leds, 8'h04);
        run_to(220); check("led_retrig_last", leds, 8'h04);
        run_to(221); check("led_retrig_off", leds, 8'h00);

        // PTT held: TX at 241, keyed at 242, 20 ticks (251..441), lockout at 442.
        run_to(240); ptt_req = 1'b1;
        run_to(241); check("ptt_entry_unkeyed", exp_ptt_n, 1);
        run_to(242); check("ptt_keyed", exp_ptt_n, 0);
        run_to(441); check("ptt_last_keyed", exp_ptt_n, 0);
                     check("ptt_no_timeout_yet", ptt_timeout, 0);
        run_to(442); check("ptt_timeout_release", exp_ptt_n, 1);
                     check("ptt_timeout_flag", ptt_timeout, 1);
        run_to(540); check("ptt_lockout_held", exp_ptt_n, 1);
        ptt_req = 1'b0;
        run_to(541); check("ptt_unkey_sticky", ptt_timeout, 1);
        run_to(545); ptt_req = 1'b1;
        run_to(546); check("ptt_rekey_clear", ptt_timeout, 0);
        run_to(547); check("ptt_rekey_keyed", exp_ptt_n, 0);

        // Inhibit aborts TX on the next edge and lockout holds until unkey.
        run_to(550); check("inh_before", exp_ptt_n, 0);
        tx_inhibit = 1'b1;
        run_to(551); check("inh_abort", exp_ptt_n, 1);
        run_to(553); tx_inhibit = 1'b0;
        run_to(560); check("inh_lockout_held", exp_ptt_n, 1);
        ptt_req = 1'b0;
        run_to(562); ptt_req = 1'b1; tx_inhibit = 1'b1;
        run_to(572); check("inh_idle_blocked", exp_ptt_n, 1);
        tx_inhibit = 1'b0;
        run_to(574); check("inh_cleared_keyed", exp_ptt_n, 0);

        // Release together with inhibit goes to IDLE, so an immediate re-key succeeds.
        run_to(575); ptt_req = 1'b0; tx_inhibit = 1'b1;
        run_to(576); ptt_req = 1'b1; tx_inhibit = 1'b0;
        run_to(578); check("release_prio_keyed", exp_ptt_n, 0);
                     check("release_prio_no_timeout", ptt_timeout, 0);

        // Asynchronous reset mid-transmit with an LED lit.
        led_act = 8'h20;
        run_to(579); led_act = 8'h00;
        run_to(580); check("pre_rst_led", leds, 8'h20);
                     check("pre_rst_keyed", exp_ptt_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ptt", exp_ptt_n, 1);
        check("async_rst_leds", leds, 8'h00);
        check("async_rst_db", dipsw_db, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

`ifdef HL_BOARD_HEARTBEAT_EN
        // 500th tick lands on edge 5001, 1000th on edge 10001.
        run_to(5000);  check("hb_low", leds[7], 0);
        run_to(5001);  check("hb_rise", leds[7], 1);
        run_to(10000); check("hb_high", leds[7], 1);
        run_to(10001); check("hb_fall", leds[7], 0);
`else
        led_act = 8'h80;
        run_to(1);  led_act = 8'h00;
                    check("led7_on", leds, 8'h80);
        run_to(40); check("led7_hold", leds, 8'h80);
        run_to(41); check("led7_off", leds, 8'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
